sbqm_top: RTL and testbench
===========================

Name: sbqm_top

Overview:
- Single-bank queue manager. Tracks customers waiting in one queue between an entry (back) photocell and an exit (front) photocell.
- Outputs the queue occupancy, empty/full flags and an estimated waiting time based on the number of active tellers.
- Sits at the top of the SBqM subsystem. Internally it is an up/down occupancy counter feeding a combinational wait-time lookup (ROM or arithmetic).

Parameters:
- CNT_W, 3, width of the occupancy count; maximum occupancy is 2^CNT_W-1 = 7.
- WT_W, 5, width of the wait-time output.
- T_UNIT, 3, minutes of service time per customer per teller.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- front_photocell  input  1  active-low; low = one customer leaves from the head this cycle.
- back_photocell  input  1  active-low; low = one customer joins at the tail this cycle.
- Tcount  input  2  number of active tellers; valid values 1..3, 0 is invalid.
- Pcount  output  3  registered current number of customers in the queue (0..7).
- Wtime  output  5  estimated waiting time for a newly arriving customer.
- empty_flag  output  1  high when Pcount == 0.
- full_flag  output  1  high when Pcount == 7.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset:
  - Pcount = 0 immediately, independent of clk.
  - Outputs follow: empty_flag = 1, full_flag = 0, Wtime = 0.
  - Reset asserted mid-operation discards the current count.
- Photocells are level-sampled on every rising clk edge. Each cycle a photocell is low counts as exactly one event; no edge detection.
- Per-edge update, with b = back low and f = front low:
  - b only: Pcount+1, saturating at 7 (further arrivals while full are ignored).
  - f only: Pcount-1, saturating at 0 (departures while empty are ignored).
  - b and f, Pcount > 0: unchanged (one in, one out). This includes the full case, where Pcount stays 7.
  - b and f, Pcount == 0: Pcount becomes 1 (nobody can leave an empty queue).
  - neither: unchanged.
- Update latency: one clock. Pcount changes on the edge after sampling.
- Flags:
  - Combinational decodes of the registered Pcount: empty_flag = (Pcount == 0), full_flag = (Pcount == 7).
  - Mutually exclusive.
- Wtime is combinational from the registered Pcount and the current Tcount input:
  - Pcount == 0: Wtime = 0.
  - Tcount == 0 (invalid): Wtime = 0. The counter keeps operating normally.
  - Otherwise: Wtime = floor(T_UNIT*(Pcount + Tcount - 1) / Tcount).
  - Maximum value is 21 (Pcount=7, Tcount=1), which fits in 5 bits with no overflow.
  - A change in Tcount affects Wtime in the same cycle; no clock is needed.
- Reference Wtime values, listed as (Pcount, Tcount) -> Wtime:
  - (1,1)->3, (7,1)->21, (6,1)->18
  - (2,2)->4, (7,2)->12
  - (1,3)->3, (7,3)->9
- No other state; no handshake.

Test Plan:
- Reset, then Tcount=2 with back_photocell low for 9 cycles -> Pcount climbs 1..7, then holds at 7; full_flag=1, empty_flag=0, Wtime=12.
- From Pcount=7, Tcount=2, back high and front low for 5 cycles -> Pcount 6,5,4,3,2; full_flag=0, Wtime=4.
- Both photocells low for 3 cycles at Pcount=2 -> Pcount stays 2, Wtime=4. Repeat at Pcount=0 -> Pcount=1 after the first edge, then holds at 1.
- Assert reset asynchronously between clock edges -> Pcount=0, empty_flag=1, full_flag=0, Wtime=0 before the next edge.
- After reset, Tcount=1, back low and front high for 6 cycles -> Pcount=6, Wtime=18. Then set Tcount=0 for 3 cycles -> Wtime=0 immediately; Pcount reaches 7 and full_flag=1.
- Front low for 3 cycles at Pcount=0 -> Pcount stays 0, empty_flag=1, Wtime=0.

Source files
------------

// File: rtl/sbqm_top.sv
// -----------------------------------------------------------------------------
// sbqm_top - single-bank queue manager.
//
// Counts customers waiting in one queue. Two active-low photocells mark the
// tail (arrivals) and the head (departures). The registered occupancy drives
// the empty/full flags and a combinational estimate of the waiting time for a
// customer who joins now, given how many tellers are active.
// -----------------------------------------------------------------------------
module sbqm_top #(
    parameter int CNT_W  = 3,   // occupancy width; maximum occupancy is 2^CNT_W-1
    parameter int WT_W   = 5,   // wait-time output width
    parameter int T_UNIT = 3    // minutes of service per customer per teller
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             front_photocell,
    input  logic             back_photocell,
    input  logic [1:0]       Tcount,
    output logic [CNT_W-1:0] Pcount,
    output logic [WT_W-1:0]  Wtime,
    output logic             empty_flag,
    output logic             full_flag
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // The numerator T_UNIT*(Pcount+Tcount-1) must not wrap; two guard bits
    // over the output width cover the largest legal operands.
    localparam int NUM_W = WT_W + 2;

    logic             arrive;
    logic             depart;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Photocells are active-low; each low sample is one customer event.
    assign arrive = ~back_photocell;
    assign depart = ~front_photocell;

    // Next occupancy: saturating up/down count. A simultaneous arrival and
    // departure cancels, except that nobody can leave an empty queue.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d; no latch is inferred.
        cnt_d = cnt_q;
        unique case ({arrive, depart})
            2'b10: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            2'b11: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d = CNT_ONE;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Occupancy register; reset clears the count immediately.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment keeps register updates order-independent.
        if (reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Pcount     = cnt_q;
    assign empty_flag = (cnt_q == CNT_ZERO);
    assign full_flag  = (cnt_q == CNT_MAX);

    // Wait-time estimate: ceil-style share of the queue per teller,
    // floor(T_UNIT*(P+T-1)/T). Division only ever by the constants 1, 2, 3,
    // so each branch is a fixed divider rather than a general one.
    logic [NUM_W-1:0] wt_sum;
    logic [NUM_W-1:0] wt_num;
    logic [NUM_W-1:0] wt_quot;

    always_comb begin
        wt_sum  = NUM_W'(cnt_q) + NUM_W'(Tcount) - NUM_W'(1);
        wt_num  = wt_sum * NUM_W'(T_UNIT);
        wt_quot = '0;
        if (cnt_q != CNT_ZERO) begin
            unique case (Tcount)
                2'd1:    wt_quot = wt_num;
                2'd2:    wt_quot = wt_num / NUM_W'(2);
                2'd3:    wt_quot = wt_num / NUM_W'(3);
                default: wt_quot = '0;   // zero tellers is invalid: report 0
            endcase
        end
    end

    assign Wtime = WT_W'(wt_quot);

endmodule

// File: tb/tb_sbqm_top.sv
// -----------------------------------------------------------------------------
// tb_sbqm_top - directed bench for sbqm_top. Inputs change 1 ns after a rising
// edge; outputs are checked at that point, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_sbqm_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       front_photocell;
    logic       back_photocell;
    logic [1:0] Tcount;
    logic [2:0] Pcount;
    logic [4:0] Wtime;
    logic       empty_flag;
    logic       full_flag;

    int n_vec = 0;
    int n_err = 0;

    sbqm_top dut (
        .clk             (clk),
        .reset           (reset),
        .front_photocell (front_photocell),
        .back_photocell  (back_photocell),
        .Tcount          (Tcount),
        .Pcount          (Pcount),
        .Wtime           (Wtime),
        .empty_flag      (empty_flag),
        .full_flag       (full_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int p, input int w,
                             input int e, input int f);
        check({tag, ".Pcount"}, int'(Pcount), p);
        check({tag, ".Wtime"}, int'(Wtime), w);
        check({tag, ".empty"}, int'(empty_flag), e);
        check({tag, ".full"}, int'(full_flag), f);
    endtask

    // Hand-computed tables: Tcount=2 fill, Tcount=2 drain, Tcount=1 fill.
    int fill2_p  [9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    int fill2_w  [9] = '{3, 4, 6, 7, 9, 10, 12, 12, 12};
    int drain2_p [5] = '{6, 5, 4, 3, 2};
    int drain2_w [5] = '{10, 9, 7, 6, 4};
    int fill1_p  [6] = '{1, 2, 3, 4, 5, 6};
    int fill1_w  [6] = '{3, 6, 9, 12, 15, 18};

    initial begin
        reset           = 1'b1;
        front_photocell = 1'b1;
        back_photocell  = 1'b1;
        Tcount          = 2'd2;
        #3;
        check_all("por", 0, 0, 1, 0);
        step();
        step();
        reset = 1'b0;

        // Fill with Tcount=2; saturates at 7.
        back_photocell = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check("fill2.Pcount", int'(Pcount), fill2_p[i]);
            check("fill2.Wtime", int'(Wtime), fill2_w[i]);
        end
        check_all("fill2.end", 7, 12, 0, 1);

        // Reference points at full occupancy for other teller counts.
        Tcount = 2'd1;
        #1;
        check("p7t1.Wtime", int'(Wtime), 21);
        Tcount = 2'd3;
        #1;
        check("p7t3.Wtime", int'(Wtime), 9);
        Tcount = 2'd2;

        // Both low while full: stays 7.
        front_photocell = 1'b0;
        step();
        check_all("bothfull", 7, 12, 0, 1);

        // Drain from 7 to 2.
        back_photocell = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("drain2.Pcount", int'(Pcount), drain2_p[i]);
            check("drain2.Wtime", int'(Wtime), drain2_w[i]);
        end
        check_all("drain2.end", 2, 4, 0, 0);

        // Both low at 2: unchanged.
        back_photocell = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("both2", 2, 4, 0, 0);
        end

        // Down to 0, then both low: becomes 1 and holds.
        back_photocell = 1'b1;
        step();
        step();
        check_all("down0", 0, 0, 1, 0);
        back_photocell = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("both0", 1, 3, 0, 0);
        end

        // Asynchronous reset between edges.
        back_photocell  = 1'b1;
        front_photocell = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all("areset", 0, 0, 1, 0);
        reset = 1'b0;

        // Fill with Tcount=1 to 6.
        Tcount         = 2'd1;
        back_photocell = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            check("fill1.Pcount", int'(Pcount), fill1_p[i]);
            check("fill1.Wtime", int'(Wtime), fill1_w[i]);
        end

        // Invalid teller count: Wtime 0 at once, counter keeps going.
        Tcount = 2'd0;
        #1;
        check_all("t0.now", 6, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("t0.fill", 7, 0, 0, 1);
        end

        // Drain to 0 with Tcount=3, then departures while empty are ignored.
        Tcount          = 2'd3;
        back_photocell  = 1'b1;
        front_photocell = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_all("p1t3", 1, 3, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("empty.dep", 0, 0, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
